// File: rtl/mycpu_store_unit_if.sv
// Data-side SRAM-like write bus between the store unit (master) and memory (slave).
// Carries the request/address/data fields plus the addr_ok/data_ok acknowledgements.
interface mycpu_store_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/mycpu_store_unit.sv
// Store unit: formats sb/sh/sw/swl/swr, queues them and issues writes on the data bus.
// Optional macro STORE_HAZARD_EN adds a load-vs-queued-store word-overlap check (ld_hazard).
module mycpu_store_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [2:0]               st_mode,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_rt,
    output logic                     st_ades,
    mycpu_store_unit_if.master       bus,
    output logic                     st_empty,
    input  logic [31:0]              ld_query_addr,
    output logic                     ld_hazard
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OstW = $clog2(MAX_OUTST + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [OstW-1:0] MaxOstC = OstW'(MAX_OUTST);

    logic [31:0] addrMem [DEPTH];
    logic [1:0]  sizeMem [DEPTH];
    logic [3:0]  strbMem [DEPTH];
    logic [31:0] dataMem [DEPTH];

    logic [PtrW-1:0] headQ, tailQ;
    logic [CntW-1:0] countQ;
    logic [OstW-1:0] outstQ;

    logic [31:0] fmtAddr, fmtData;
    logic [1:0]  fmtSize;
    logic [3:0]  fmtStrb;
    logic        fifoEmpty, push, pop, dataOk;

    always_comb begin
        st_ades = st_valid & ((st_mode == 3'd1 & st_addr[0]) |
                              (st_mode == 3'd2 & (|st_addr[1:0])) |
                              (st_mode > 3'd4));
    end

    always_comb begin
        fmtAddr = st_addr;
        fmtSize = 2'd2;
        fmtStrb = 4'b1111;
        fmtData = st_rt;
        case (st_mode)
            3'd0: begin
                fmtSize = 2'd0;
                fmtStrb = 4'b0001 << st_addr[1:0];
                fmtData = {4{st_rt[7:0]}};
            end
            3'd1: begin
                fmtSize = 2'd1;
                fmtStrb = st_addr[1] ? 4'b1100 : 4'b0011;
                fmtData = {2{st_rt[15:0]}};
            end
            // swl writes the high bytes of rt into the low lanes up to the addressed byte
            3'd3: begin
                fmtAddr = {st_addr[31:2], 2'b00};
                unique case (st_addr[1:0])
                    2'b00: begin fmtStrb = 4'b0001; fmtData = {24'b0, st_rt[31:24]}; end
                    2'b01: begin fmtStrb = 4'b0011; fmtData = {16'b0, st_rt[31:16]}; end
                    2'b10: begin fmtStrb = 4'b0111; fmtData = {8'b0, st_rt[31:8]}; end
                    2'b11: begin fmtStrb = 4'b1111; fmtData = st_rt; end
                endcase
            end
            3'd4: begin
                fmtAddr = {st_addr[31:2], 2'b00};
                unique case (st_addr[1:0])
                    2'b00: begin fmtStrb = 4'b1111; fmtData = st_rt; end
                    2'b01: begin fmtStrb = 4'b1110; fmtData = {st_rt[23:0], 8'b0}; end
                    2'b10: begin fmtStrb = 4'b1100; fmtData = {st_rt[15:0], 16'b0}; end
                    2'b11: begin fmtStrb = 4'b1000; fmtData = {st_rt[7:0], 24'b0}; end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        fifoEmpty        = (countQ == '0);
        st_ready         = (countQ < DepthC);
        push             = st_valid & st_ready & ~st_ades;
        bus.data_req     = ~fifoEmpty & (outstQ < MaxOstC);
        pop              = bus.data_req & bus.data_addr_ok;
        dataOk           = bus.data_data_ok & (outstQ != '0);
        bus.data_wr      = 1'b1;
        bus.data_addr    = fifoEmpty ? 32'b0 : addrMem[headQ];
        bus.data_size    = fifoEmpty ? 2'b0 : sizeMem[headQ];
        bus.data_wstrb   = fifoEmpty ? 4'b0 : strbMem[headQ];
        bus.data_wdata   = fifoEmpty ? 32'b0 : dataMem[headQ];
        st_empty         = fifoEmpty & (outstQ == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[tailQ] <= fmtAddr;
            sizeMem[tailQ] <= fmtSize;
            strbMem[tailQ] <= fmtStrb;
            dataMem[tailQ] <= fmtData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            outstQ <= '0;
        end else begin
            if (push) tailQ <= tailQ + 1'b1;
            if (pop)  headQ <= headQ + 1'b1;
            if (push && !pop)      countQ <= countQ + 1'b1;
            else if (!push && pop) countQ <= countQ - 1'b1;
            if (pop && !dataOk)      outstQ <= outstQ + 1'b1;
            else if (!pop && dataOk) outstQ <= outstQ - 1'b1;
        end
    end

`ifdef STORE_HAZARD_EN
    // Only entries still in the FIFO count; issued stores are the memory's problem.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CntW'(i) < countQ) &&
                (addrMem[headQ + PtrW'(i)][31:2] == ld_query_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end
    logic [1:0] unusedLdLow;
    assign unusedLdLow = ld_query_addr[1:0];
`else
    assign ld_hazard = 1'b0;
    logic unusedLdQuery;
    assign unusedLdQuery = ^ld_query_addr;
`endif
endmodule

// File: doc/mycpu_store_unit.md
Name: mycpu_store_unit

Overview:
- Store-side counterpart of the WB load-data formatter.
- Takes store ops from the MEM stage (sb/sh/sw/swl/swr); computes byte strobes and lane-aligned write data; checks alignment.
- Queues accepted stores in a small FIFO and issues them to the data SRAM-like bus with a req/addr_ok/data_ok handshake.
- Tracks outstanding writes so the pipeline knows when memory is drained.

Parameters:
DEPTH, 2, store FIFO entries (power of two, >=2)
MAX_OUTST, 2, max writes issued (addr_ok seen) but not yet acknowledged (data_ok)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
st_valid  in  1  MEM stage presents a store
st_ready  out  1  unit can accept a store
st_mode  in  3  000 sb, 001 sh, 010 sw, 011 swl, 100 swr; others illegal
st_addr  in  32  effective address (ALU result)
st_rt  in  32  rt register contents
st_ades  out  1  address-error on store (combinational)
data_req  out  1  bus write request
data_wr  out  1  constant 1
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  bus address
data_wstrb  out  4  byte enables
data_wdata  out  32  lane-aligned write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  write completed
st_empty  out  1  FIFO empty and zero outstanding
ld_query_addr  in  32  load address for hazard check (STORE_HAZARD_EN only)
ld_hazard  out  1  pending store overlaps load word (STORE_HAZARD_EN only)

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset.
- Reset: FIFO pointers/count 0, outstanding 0, data_req 0, st_empty 1, ld_hazard 0. data_addr/data_wstrb/data_wdata/data_size read 0 whenever the FIFO is empty.
- Reset mid-operation discards queued and outstanding stores; later data_ok pulses are ignored while outstanding==0.
- Acceptance:
  - st_ready = (count < DEPTH); no same-cycle pop bypass.
  - Push on st_valid & st_ready & ~st_ades.
- st_ades = st_valid & ((sh & addr[0]) | (sw & addr[1:0]!=0) | illegal mode). A store that raises st_ades is never enqueued.
- Formatting at push, stored per entry as addr/size/wstrb/wdata. a = st_addr[1:0].
  - sb: wstrb = 1<<a; wdata = {4{rt[7:0]}}; size 0; addr = st_addr.
  - sh: wstrb = a[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}; size 1; addr = st_addr.
  - sw: wstrb 1111; wdata rt; size 2; addr = st_addr.
  - swl:
    - a=00 → 0001, {24'b0, rt[31:24]}
    - a=01 → 0011, {16'b0, rt[31:16]}
    - a=10 → 0111, {8'b0, rt[31:8]}
    - a=11 → 1111, rt
  - swr:
    - a=00 → 1111, rt
    - a=01 → 1110, {rt[23:0], 8'b0}
    - a=10 → 1100, {rt[15:0], 16'b0}
    - a=11 → 1000, {rt[7:0], 24'b0}
  - swl/swr: size 2, addr = {st_addr[31:2], 2'b00}.
- Issue:
  - data_req = ~fifo_empty & (outst < MAX_OUTST). Bus outputs show the FIFO head.
  - Pop on data_req & data_addr_ok.
  - Earliest data_req for a store is the cycle after its push.
  - Head is held stable while data_req=1 and data_addr_ok=0.
- Outstanding counter: +1 on pop, -1 on data_ok. Both in one cycle → unchanged. data_ok at outst==0 is ignored.
- FIFO full and pop in the same cycle: st_ready stays 0 that cycle; the push is taken next cycle.
- Pointers wrap modulo DEPTH.
- Stores reach the bus in acceptance order.

Optional Feature:
- Macro STORE_HAZARD_EN.
- Defined: ld_hazard = 1 when any valid FIFO entry has addr[31:2] == ld_query_addr[31:2] (combinational, every cycle). Outstanding (already issued) stores are not checked.
- Undefined: ld_query_addr is unused and ld_hazard is tied to 0.

Test Plan:
- sb sweep: rt=0x11223344, addr 0x100..0x103, addr_ok=1 → wstrb 0001/0010/0100/1000, wdata 0x44444444, size 0, addr unchanged.
- swl/swr: rt=0xAABBCCDD, addr 0x201 → swl wstrb 0011, wdata 0x0000AABB, addr 0x200; swr wstrb 1110, wdata 0xBBCCDD00, addr 0x200.
- Alignment: sw at 0x302 and sh at 0x305 → st_ades=1, no push, data_req stays 0. sh at 0x306 → wstrb 1100.
- Backpressure: addr_ok=0, push 3 stores with DEPTH=2 → st_ready=0 after 2. Raise addr_ok → stores issue in order, head stable while stalled.
- Outstanding: MAX_OUTST=2, data_ok held low, 3 stores queued → 2 issue, data_req drops. One data_ok → third issues. st_empty=1 only after the final data_ok.
- Hazard (STORE_HAZARD_EN): sw 0x400 queued, addr_ok=0, ld_query_addr=0x402 → ld_hazard=1. 0x404 → 0. After pop → 0.
